regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Write-port controller for the 8x8 register file. Two writeback sources share the file's single write port: requester 0 is the ALU and requester 1 is memory/load.
- Arbitrates the sources round-robin and drives the file's write-enable, address and data from registered outputs.
- Keeps a per-register busy scoreboard. Issue logic uses it to detect read-after-write hazards and to refuse double reservations.
- Sits between the execute/memory stages and the register file's write inputs.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 3, register address width
- NUM_REGS, 8, number of registers (2**ADDR_W); register 0 is hardwired zero

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  ALU writeback request
- req0_reg  in  ADDR_W  destination register, requester 0
- req0_data  in  DATA_W  write data, requester 0
- req0_ready  out  1  grant to requester 0 (combinational)
- req1_valid  in  1  load writeback request
- req1_reg  in  ADDR_W  destination register, requester 1
- req1_data  in  DATA_W  write data, requester 1
- req1_ready  out  1  grant to requester 1 (combinational)
- rsv_valid  in  1  issue stage reserves a destination register
- rsv_reg  in  ADDR_W  register being reserved
- rsv_ready  out  1  reservation accepted (combinational)
- chk_reg1  in  ADDR_W  source operand 1 to check
- chk_reg2  in  ADDR_W  source operand 2 to check
- hazard  out  1  either checked source is busy (combinational)
- rf_we  out  1  register file write enable (registered)
- rf_wreg  out  ADDR_W  register file write address (registered)
- rf_wdata  out  DATA_W  register file write data (registered)
- busy_mask  out  NUM_REGS  scoreboard state; bit 0 always 0

Behaviour:
Arbitration
- Transfer on requester n = reqn_valid & reqn_ready.
- At most one ready per cycle. Ready never depends on the loser's state beyond the valid inputs.
- Single valid requester: that requester gets ready the same cycle.
- Both valid: grant the requester that did not win the last contested cycle.
- Contention state `last` updates only on cycles where both requesters are valid. It resets to 1, so requester 0 wins the first contention.

Write stage
- On posedge after a transfer: rf_we <= (granted reg != 0); rf_wreg <= granted reg; rf_wdata <= granted data.
- With no transfer, rf_we <= 0 and rf_wreg/rf_wdata hold their values.
- Latency: request accepted in cycle N, rf_we high in cycle N+1, register file loads at end of N+1.
- A transfer to register 0 is accepted (ready asserted) but produces rf_we = 0.

Scoreboard
- busy[r] set on posedge when rsv_valid & rsv_ready & rsv_reg == r and r != 0.
- busy[r] cleared on posedge when rf_we & rf_wreg == r. This is the same edge the register file writes.
- Set and clear of the same register on the same edge: set wins, because a new reservation follows the retiring write.
- rsv_ready = (rsv_reg == 0) | ~busy[rsv_reg]. A reservation to a busy register is refused and the issue stage stalls.
- hazard = busy[chk_reg1] | busy[chk_reg2]. Register 0 never causes a hazard.
- Writes to a non-busy register are legal and do not affect the scoreboard.

Reset
- On rst, at the next posedge: rf_we = 0, rf_wreg = 0, rf_wdata = 0, busy_mask = 0, last = 1.
- Reset mid-operation drops any in-flight write: rf_we is low the cycle after rst, and pending reservations are discarded.
- Combinational readies still evaluate during reset, but no transfer is recorded while rst = 1.

Test Plan:
- Reset, then req0 only, reg 3, data 0x5A: req0_ready = 1 in cycle N. In cycle N+1, rf_we = 1, rf_wreg = 3, rf_wdata = 0x5A. In cycle N+2, rf_we = 0.
- Both valid for 4 cycles (req0 reg 1, data 0x11; req1 reg 2, data 0x22): grants go 0, 1, 0, 1. The rf_wreg sequence is 1, 2, 1, 2.
- rsv_valid for reg 5, then chk_reg1 = 5: busy_mask = 0x20 and hazard = 1. A second rsv to 5 sees rsv_ready = 0. After req1 writes reg 5: rf_we cycle, then busy_mask = 0 and hazard = 0.
- Same edge: rsv reg 4 accepted while rf_we retires reg 4 -> busy[4] remains 1.
- req0 writes reg 0, data 0xFF: req0_ready = 1, rf_we stays 0. rsv to reg 0 gives rsv_ready = 1 and busy_mask stays 0. chk_reg1 = chk_reg2 = 0 gives hazard = 0.
- rst asserted the cycle after a transfer and after reservations of regs 2 and 6: next cycle rf_we = 0 and busy_mask = 0. The first contention after reset grants req0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of signals between the writeback sources, the issue stage and the
// register-file write-port controller.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
);
    logic                req0_valid;
    logic [ADDR_W-1:0]   req0_reg;
    logic [DATA_W-1:0]   req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [ADDR_W-1:0]   req1_reg;
    logic [DATA_W-1:0]   req1_data;
    logic                req1_ready;
    logic                rsv_valid;
    logic [ADDR_W-1:0]   rsv_reg;
    logic                rsv_ready;
    logic [ADDR_W-1:0]   chk_reg1;
    logic [ADDR_W-1:0]   chk_reg2;
    logic                hazard;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_wreg;
    logic [DATA_W-1:0]   rf_wdata;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output req0_valid, req0_reg, req0_data,
        input  req0_ready,
        output req1_valid, req1_reg, req1_data,
        input  req1_ready,
        output rsv_valid, rsv_reg,
        input  rsv_ready,
        output chk_reg1, chk_reg2,
        input  hazard,
        input  rf_we, rf_wreg, rf_wdata, busy_mask
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        output req0_ready,
        input  req1_valid, req1_reg, req1_data,
        output req1_ready,
        input  rsv_valid, rsv_reg,
        output rsv_ready,
        input  chk_reg1, chk_reg2,
        output hazard,
        output rf_we, rf_wreg, rf_wdata, busy_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-port arbiter for the 8x8 register file (ALU vs. load
// writeback) with a per-register busy scoreboard for hazard detection.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    logic                grant0;
    logic                grant1;
    logic                contend;
    logic                xfer;
    logic [ADDR_W-1:0]   sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic                rsv_ok;
    logic                rsv_fire;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_next;

    // last_p0 is 1 when requester 1 won the most recent contended cycle
    logic                last_p0;
    logic [NUM_REGS-1:0] busy_p0;
    logic                vld_p1;
    logic [ADDR_W-1:0]   wreg_p1;
    logic [DATA_W-1:0]   wdata_p1;

    always_comb begin
        contend  = bus.req0_valid & bus.req1_valid;
        grant0   = bus.req0_valid & (~bus.req1_valid | last_p0);
        grant1   = bus.req1_valid & (~bus.req0_valid | ~last_p0);
        xfer     = grant0 | grant1;
        sel_reg  = grant1 ? bus.req1_reg  : bus.req0_reg;
        sel_data = grant1 ? bus.req1_data : bus.req0_data;
    end

    always_comb begin
        rsv_ok   = (bus.rsv_reg == '0) | ~busy_p0[bus.rsv_reg];
        rsv_fire = bus.rsv_valid & rsv_ok & (bus.rsv_reg != '0);
        set_mask = '0;
        clr_mask = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            set_mask[r] = rsv_fire & (bus.rsv_reg == ADDR_W'(r));
            clr_mask[r] = vld_p1   & (wreg_p1     == ADDR_W'(r));
        end
        // set is applied after clear so a reservation survives a same-edge retire
        busy_next = ((busy_p0 & ~clr_mask) | set_mask) & {{(NUM_REGS-1){1'b1}}, 1'b0};
    end

    // Stage p0 -> p1: capture granted write, update contention and scoreboard
    always_ff @(posedge clk) begin
        if (rst) begin
            last_p0  <= 1'b1;
            busy_p0  <= '0;
            vld_p1   <= 1'b0;
            wreg_p1  <= '0;
            wdata_p1 <= '0;
        end else begin
            if (contend) begin
                last_p0 <= grant1;
            end
            busy_p0 <= busy_next;
            if (xfer) begin
                vld_p1   <= (sel_reg != '0);
                wreg_p1  <= sel_reg;
                wdata_p1 <= sel_data;
            end else begin
                vld_p1   <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsv_ready  = rsv_ok;
    assign bus.hazard     = busy_p0[bus.chk_reg1] | busy_p0[bus.chk_reg2];
    assign bus.rf_we      = vld_p1;
    assign bus.rf_wreg    = wreg_p1;
    assign bus.rf_wdata   = wdata_p1;
    assign bus.busy_mask  = busy_p0;

endmodule
